i2c_master_nbyte: RTL and testbench

- Parametrised write-only I2C master for codec register programming (WM8731 and similar).
- Successor to the fixed 24-bit controller, with four additions:
  - configurable transfer length in bytes;
  - configurable SCL timing;
  - per-byte ACK checking with NACK abort and an error flag;
  - a one-cycle completion pulse.
- Sits between the codec-configuration sequencer and the board SCL/SDA pins.

---
 rtl/i2c_master_nbyte_pkg.sv | 25 ++
 rtl/i2c_qtick_gen.sv | 31 +++
 rtl/i2c_master_nbyte.sv | 172 +++++++++++++++++
 tb/tb_i2c_master_nbyte.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_nbyte_pkg.sv
// Shared definitions for the N-byte write-only I2C master: FSM encoding,
// quarter-phase markers and a counter-width helper.
package i2c_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_ACK,
        ST_STOP
    } state_e;

    localparam logic [2:0] PH_START_LAST = 3'd1;  // START lasts two quarters
    localparam logic [2:0] PH_SCL_HI     = 3'd2;  // SCL is high from this quarter on
    localparam logic [2:0] PH_ACK_SAMPLE = 3'd2;
    localparam logic [2:0] PH_SLOT_LAST  = 3'd3;
    localparam logic [2:0] PH_STOP_REL   = 3'd4;  // SDA released: stop condition
    localparam logic [2:0] PH_STOP_LAST  = 3'd5;

    // Width needed to hold 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period tick generator; held at zero while disabled so every
// transaction starts phase-aligned.
module i2c_qtick_gen
    import i2c_defs::*;
#(
    parameter int QDIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic qtick
);
    localparam int W = cnt_w(QDIV);
    localparam logic [W-1:0] LAST = W'(QDIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (en && cnt_q != LAST)
            cnt_d = cnt_q + 1'b1;
    end

    assign qtick = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/i2c_master_nbyte.sv
// Write-only I2C master sending NBYTES bytes MSB-first with per-byte ACK
// checking, NACK abort and a completion pulse.
module i2c_master_nbyte
    import i2c_defs::*;
#(
    parameter int NBYTES    = 3,
    parameter int QDIV      = 125,
    parameter int ACK_CHECK = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*NBYTES-1:0]   din,
    input  logic                  wr_i2c,
    output logic                  i2c_sclk,
    inout  wire                   i2c_sdat,
    output logic                  i2c_idle,
    output logic                  done_tick,
    output logic                  ack_err
);
    localparam int BW = cnt_w(NBYTES);
    localparam int DW = 8 * NBYTES;

    state_e          state_q, state_d;
    logic [2:0]      ph_q, ph_d;
    logic [2:0]      bit_q, bit_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic [DW-1:0]   sreg_q, sreg_d;
    logic            sclk_q, sclk_d;
    logic            sda_low_q, sda_low_d;
    logic            idle_q, idle_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic            qtick;
    logic            sda_in;

    assign sda_in = i2c_sdat;

    i2c_qtick_gen #(.QDIV(QDIV)) u_qtick (
        .clk   (clk),
        .reset (reset),
        .en    (state_q != ST_IDLE),
        .qtick (qtick)
    );

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sreg_d    = sreg_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (wr_i2c) begin
                    sreg_d    = din;
                    ack_err_d = 1'b0;
                    ph_d      = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (qtick) begin
                    if (ph_q == PH_START_LAST) begin
                        ph_d    = '0;
                        bit_d   = 3'd7;
                        byte_d  = BW'(NBYTES - 1);
                        state_d = ST_DATA;
                    end else begin
                        ph_d = ph_q + 3'd1;
                    end
                end
            end
            ST_DATA: begin
                if (qtick) begin
                    if (ph_q == PH_SLOT_LAST) begin
                        ph_d   = '0;
                        sreg_d = sreg_q << 1;
                        if (bit_q == 3'd0) state_d = ST_ACK;
                        else               bit_d   = bit_q - 3'd1;
                    end else begin
                        ph_d = ph_q + 3'd1;
                    end
                end
            end
            ST_ACK: begin
                if (qtick) begin
                    if (ph_q == PH_ACK_SAMPLE && ACK_CHECK != 0 && sda_in)
                        ack_err_d = 1'b1;
                    if (ph_q == PH_SLOT_LAST) begin
                        ph_d = '0;
                        // ack_err_q is only ever set by this transaction's NACK
                        if (ack_err_q || byte_q == '0) begin
                            state_d = ST_STOP;
                        end else begin
                            byte_d  = byte_q - 1'b1;
                            bit_d   = 3'd7;
                            state_d = ST_DATA;
                        end
                    end else begin
                        ph_d = ph_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (qtick) begin
                    if (ph_q == PH_STOP_LAST) begin
                        ph_d    = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ph_d = ph_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin levels follow the phase being entered so they are registered.
        sclk_d    = 1'b1;
        sda_low_d = 1'b0;
        idle_d    = 1'b0;
        unique case (state_d)
            ST_IDLE:  idle_d = 1'b1;
            ST_START: sda_low_d = 1'b1;
            ST_DATA: begin
                sclk_d    = (ph_d >= PH_SCL_HI);
                sda_low_d = ~sreg_d[DW-1];
            end
            ST_ACK:   sclk_d = (ph_d >= PH_SCL_HI);
            ST_STOP: begin
                sclk_d    = (ph_d >= PH_SCL_HI);
                sda_low_d = (ph_d < PH_STOP_REL);
            end
            default:  idle_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sreg_q    <= '0;
            sclk_q    <= 1'b1;
            sda_low_q <= 1'b0;
            idle_q    <= 1'b1;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sreg_q    <= sreg_d;
            sclk_q    <= sclk_d;
            sda_low_q <= sda_low_d;
            idle_q    <= idle_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign i2c_sclk  = sclk_q;
    assign i2c_sdat  = sda_low_q ? 1'b0 : 1'bz;
    assign i2c_idle  = idle_q;
    assign done_tick = done_q;
    assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_i2c_master_nbyte.sv
// Directed bench: three masters (3-byte checked, 3-byte unchecked, 2-byte)
// on separate pulled-up buses, one shared slave/monitor selected by sel.
module tb_i2c_master_nbyte;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [23:0] din0 = 24'h0, din1 = 24'h0;
    logic [15:0] din2 = 16'h0;
    logic wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0;
    logic scl0, scl1, scl2, idle0, idle1, idle2;
    logic done0, done1, done2, err0, err1, err2;
    wire  sda0, sda1, sda2;

    int   sel = 0;
    logic [7:0] ack_mask = 8'hFF;
    logic tb_low = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    pullup (sda0);
    pullup (sda1);
    pullup (sda2);
    assign sda0 = (sel == 0 && tb_low) ? 1'b0 : 1'bz;
    assign sda1 = (sel == 1 && tb_low) ? 1'b0 : 1'bz;
    assign sda2 = (sel == 2 && tb_low) ? 1'b0 : 1'bz;

    i2c_master_nbyte #(.NBYTES(3), .QDIV(4), .ACK_CHECK(1)) u0 (
        .clk(clk), .reset(rst_n), .din(din0), .wr_i2c(wr0), .i2c_sclk(scl0),
        .i2c_sdat(sda0), .i2c_idle(idle0), .done_tick(done0), .ack_err(err0));
    i2c_master_nbyte #(.NBYTES(3), .QDIV(4), .ACK_CHECK(0)) u1 (
        .clk(clk), .reset(rst_n), .din(din1), .wr_i2c(wr1), .i2c_sclk(scl1),
        .i2c_sdat(sda1), .i2c_idle(idle1), .done_tick(done1), .ack_err(err1));
    i2c_master_nbyte #(.NBYTES(2), .QDIV(4), .ACK_CHECK(1)) u2 (
        .clk(clk), .reset(rst_n), .din(din2), .wr_i2c(wr2), .i2c_sclk(scl2),
        .i2c_sdat(sda2), .i2c_idle(idle2), .done_tick(done2), .ack_err(err2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic scl_m, sda_m, done_m;
    always_comb begin
        case (sel)
            0:       begin scl_m = scl0; sda_m = (sda0 !== 1'b0); done_m = done0; end
            1:       begin scl_m = scl1; sda_m = (sda1 !== 1'b0); done_m = done1; end
            default: begin scl_m = scl2; sda_m = (sda2 !== 1'b0); done_m = done2; end
        endcase
    end

    // Bus monitor + ACKing slave, sampled once per cycle away from the edge.
    logic       scl_p = 1'b1, sda_p = 1'b1, in_ack = 1'b0;
    logic [3:0] bitcnt = 4'd0;
    logic [2:0] bidx = 3'd0;
    logic [7:0] shreg = 8'h0;
    logic [7:0] mb [0:255];
    int nb = 0, nstart = 0, nstop = 0, ndone = 0;

    always @(negedge clk) begin
        scl_p <= scl_m;
        sda_p <= sda_m;
        if (done_m) ndone <= ndone + 1;
        if (scl_p && scl_m && sda_p && !sda_m) begin
            nstart <= nstart + 1;
            bitcnt <= 4'd0;
            bidx   <= 3'd0;
            in_ack <= 1'b0;
            tb_low <= 1'b0;
        end else if (scl_p && scl_m && !sda_p && sda_m) begin
            nstop  <= nstop + 1;
            in_ack <= 1'b0;
            tb_low <= 1'b0;
        end else if (!scl_p && scl_m) begin
            if (!in_ack && bitcnt < 4'd8) begin
                shreg  <= {shreg[6:0], sda_m};
                bitcnt <= bitcnt + 4'd1;
                if (bitcnt == 4'd7) begin
                    mb[nb[7:0]] <= {shreg[6:0], sda_m};
                    nb <= nb + 1;
                end
            end
        end else if (scl_p && !scl_m) begin
            if (in_ack) begin
                in_ack <= 1'b0;
                tb_low <= 1'b0;
                bitcnt <= 4'd0;
                bidx   <= bidx + 3'd1;
            end else if (bitcnt == 4'd8) begin
                in_ack <= 1'b1;
                tb_low <= ack_mask[bidx];
            end
        end
    end

    task automatic wait_done(input int t0, output int lat);
        int n;
        lat = -1;
        n = 0;
        while (lat < 0 && n < 3000) begin
            if (done_m) lat = cyc - t0;
            else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic start_wr(input int s, output int t0);
        @(negedge clk);
        case (s)
            0:       wr0 = 1'b1;
            1:       wr1 = 1'b1;
            default: wr2 = 1'b1;
        endcase
        @(negedge clk);
        wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
        t0 = cyc;
    endtask

    task automatic test_reset;
        int bad;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({scl0, sda0 === 1'b1, idle0, done0, err0} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_assert: got scl/sda/idle/done/err=%b expected 11100",
                     {scl0, sda0 === 1'b1, idle0, done0, err0});
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if ({scl0, sda0 === 1'b1, idle0, done0, err0} !== 5'b11100) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_idle_stable: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_full_write;
        int t0, lat, b0, s0, p0, d0;
        sel = 0; ack_mask = 8'hFF; din0 = 24'hAA3CC3;
        b0 = nb; s0 = nstart; p0 = nstop; d0 = ndone;
        start_wr(0, t0);
        wait_done(t0, lat);
        checks++;
        if (lat < 463 || lat > 465) begin
            errors++;
            $display("FAIL full_latency: got %0d expected 464", lat);
        end
        repeat (20) @(negedge clk);
        checks++;
        if ({mb[b0[7:0]], mb[8'(b0 + 1)], mb[8'(b0 + 2)]} !== 24'hAA3CC3 || nb - b0 !== 3) begin
            errors++;
            $display("FAIL full_bytes: got %0d bytes %h%h%h expected 3 bytes aa3cc3",
                     nb - b0, mb[b0[7:0]], mb[8'(b0 + 1)], mb[8'(b0 + 2)]);
        end
        checks++;
        if ({nstart - s0, nstop - p0, ndone - d0} !== {32'd1, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL full_framing: got start/stop/done %0d/%0d/%0d expected 1/1/1",
                     nstart - s0, nstop - p0, ndone - d0);
        end
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL full_ack_err: got %b expected 0", err0);
        end
    endtask

    task automatic test_nack_abort;
        int t0, lat, b0, p0;
        sel = 0; ack_mask = 8'h01; din0 = 24'hAA3CC3;
        b0 = nb; p0 = nstop;
        start_wr(0, t0);
        wait_done(t0, lat);
        checks++;
        if (lat < 319 || lat > 321) begin
            errors++;
            $display("FAIL nack_latency: got %0d expected 320", lat);
        end
        checks++;
        if (err0 !== 1'b1) begin
            errors++;
            $display("FAIL nack_err_at_done: got %b expected 1", err0);
        end
        repeat (50) @(negedge clk);
        checks++;
        if (nb - b0 !== 2 || {mb[b0[7:0]], mb[8'(b0 + 1)]} !== 16'hAA3C || nstop - p0 !== 1) begin
            errors++;
            $display("FAIL nack_bytes: got %0d bytes %h%h stops %0d expected 2 bytes aa3c stops 1",
                     nb - b0, mb[b0[7:0]], mb[8'(b0 + 1)], nstop - p0);
        end
        checks++;
        if (err0 !== 1'b1) begin
            errors++;
            $display("FAIL nack_err_sticky: got %b expected 1", err0);
        end
        ack_mask = 8'hFF;
        start_wr(0, t0);
        checks++;
        if (err0 !== 1'b0) begin
            errors++;
            $display("FAIL nack_err_clear: got %b expected 0", err0);
        end
        wait_done(t0, lat);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_ack_ignored;
        int t0, lat, b0;
        sel = 1; ack_mask = 8'h00; din1 = 24'hAA3CC3;
        b0 = nb;
        start_wr(1, t0);
        wait_done(t0, lat);
        checks++;
        if (lat < 463 || lat > 465) begin
            errors++;
            $display("FAIL noack_latency: got %0d expected 464", lat);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (nb - b0 !== 3 || {mb[b0[7:0]], mb[8'(b0 + 1)], mb[8'(b0 + 2)]} !== 24'hAA3CC3 || err1 !== 1'b0) begin
            errors++;
            $display("FAIL noack_bytes: got %0d bytes %h%h%h err %b expected 3 bytes aa3cc3 err 0",
                     nb - b0, mb[b0[7:0]], mb[8'(b0 + 1)], mb[8'(b0 + 2)], err1);
        end
        sel = 0; ack_mask = 8'hFF;
    endtask

    task automatic test_back_to_back;
        int t0, lat, b0, s0, d0;
        sel = 0; ack_mask = 8'hFF; din0 = 24'hAA3CC3;
        b0 = nb; s0 = nstart; d0 = ndone;
        start_wr(0, t0);
        repeat (100) @(negedge clk);
        wr0 = 1'b1; din0 = 24'h3AC33C;
        @(negedge clk);
        wr0 = 1'b0;
        wait_done(t0, lat);
        checks++;
        if (lat < 463 || lat > 465 || nb - b0 !== 3 ||
            {mb[b0[7:0]], mb[8'(b0 + 1)], mb[8'(b0 + 2)]} !== 24'hAA3CC3) begin
            errors++;
            $display("FAIL busy_ignored: got lat %0d bytes %0d %h%h%h expected 464 3 aa3cc3",
                     lat, nb - b0, mb[b0[7:0]], mb[8'(b0 + 1)], mb[8'(b0 + 2)]);
        end
        wr0 = 1'b1;
        @(negedge clk);
        wr0 = 1'b0;
        t0 = cyc;
        checks++;
        if ({idle0, scl0, sda0 === 1'b0} !== 3'b011) begin
            errors++;
            $display("FAIL done_cycle_start: got idle/scl/sda_low=%b expected 011",
                     {idle0, scl0, sda0 === 1'b0});
        end
        wait_done(t0, lat);
        repeat (20) @(negedge clk);
        checks++;
        if (lat < 463 || lat > 465 || nstart - s0 !== 2 || ndone - d0 !== 2 ||
            {mb[8'(b0 + 3)], mb[8'(b0 + 4)], mb[8'(b0 + 5)]} !== 24'h3AC33C) begin
            errors++;
            $display("FAIL back_to_back: got lat %0d starts %0d dones %0d bytes %h%h%h expected 464 2 2 3ac33c",
                     lat, nstart - s0, ndone - d0, mb[8'(b0 + 3)], mb[8'(b0 + 4)], mb[8'(b0 + 5)]);
        end
    endtask

    task automatic test_reset_mid_byte;
        int t0;
        sel = 0; ack_mask = 8'hFF; din0 = 24'hAA3CC3;
        start_wr(0, t0);
        repeat (216) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({scl0, sda0 === 1'b1, idle0, done0, err0} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_mid_byte: got scl/sda/idle/done/err=%b expected 11100",
                     {scl0, sda0 === 1'b1, idle0, done0, err0});
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_full_write();
    endtask

    task automatic test_two_bytes;
        int t0, lat, b0;
        sel = 2; ack_mask = 8'hFF; din2 = 16'h1E05;
        b0 = nb;
        start_wr(2, t0);
        wait_done(t0, lat);
        checks++;
        if (lat < 319 || lat > 321) begin
            errors++;
            $display("FAIL two_byte_latency: got %0d expected 320", lat);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (nb - b0 !== 2 || {mb[b0[7:0]], mb[8'(b0 + 1)]} !== 16'h1E05 || err2 !== 1'b0) begin
            errors++;
            $display("FAIL two_byte_data: got %0d bytes %h%h err %b expected 2 bytes 1e05 err 0",
                     nb - b0, mb[b0[7:0]], mb[8'(b0 + 1)], err2);
        end
        sel = 0;
    endtask

    initial begin
        #2;
        test_reset();
        test_full_write();
        test_nack_abort();
        test_ack_ignored();
        test_back_to_back();
        test_reset_mid_byte();
        test_two_bytes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
